secded_dec_pipe: RTL and testbench

Parametrised, pipelined SECDED (single-error-correct, double-error-detect) Hamming decoder, successor to the fixed 8-bit decoder. It accepts extended-Hamming codewords of any data width on a valid/ready stream and returns corrected data with per-beat error flags and syndrome. It also keeps saturating single/double error counters for memory scrubbing and health reporting. It sits between the dual-port RAM read port and the consumer.

---
 rtl/secded_pkg.sv | 43 ++++
 rtl/secded_dec_pipe_if.sv | 38 +++
 rtl/secded_syndrome.sv | 24 ++
 rtl/secded_dec_pipe.sv | 116 +++++++++++
 tb/tb_secded_dec_pipe.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/secded_pkg.sv
// Shared types and elaboration helpers for the parametrised SECDED decoder family.
package secded_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_CW     = 72;

    typedef enum logic [1:0] {
        CLEAN,
        SEC,
        DED
    } secded_class_e;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int calc_r(input int data_w);
        int r;
        r = 0;
        for (int i = 15; i >= 1; i--) begin
            if ((1 << i) >= data_w + i + 1) r = i;
        end
        return r;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Gathers the non-parity positions 1..n in ascending order, LSB first.
    function automatic logic [MAX_DATA_W-1:0] extract_data(input logic [MAX_CW-1:0] codeword,
                                                           input int n);
        logic [MAX_DATA_W-1:0] data;
        int idx;
        data = '0;
        idx  = 0;
        for (int k = 0; k < MAX_CW - 1; k++) begin
            if ((k + 1) <= n && !is_pow2(k + 1) && idx < MAX_DATA_W) begin
                data[6'(idx)] = codeword[7'(k)];
                idx++;
            end
        end
        return data;
    endfunction

endpackage

// File: rtl/secded_dec_pipe_if.sv
// Stream interface of the SECDED decoder: codeword in, corrected beat out, counter control.
interface secded_dec_pipe_if
    import secded_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    localparam int R  = calc_r(DATA_W);
    localparam int CW = DATA_W + R + 1;

    logic              i_valid;
    logic              o_ready;
    logic [CW-1:0]     i_data;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [R-1:0]      o_syndrome;
    logic              o_single_bit_error_detected;
    logic              o_2_bit_error_detected;
    logic              i_cnt_clr;
    logic [CNT_W-1:0]  o_sec_cnt;
    logic [CNT_W-1:0]  o_ded_cnt;

    modport slave (
        input  i_valid, i_data, i_ready, i_cnt_clr,
        output o_ready, o_valid, o_data, o_syndrome,
               o_single_bit_error_detected, o_2_bit_error_detected,
               o_sec_cnt, o_ded_cnt
    );

    modport master (
        output i_valid, i_data, i_ready, i_cnt_clr,
        input  o_ready, o_valid, o_data, o_syndrome,
               o_single_bit_error_detected, o_2_bit_error_detected,
               o_sec_cnt, o_ded_cnt
    );

endinterface

// File: rtl/secded_syndrome.sv
// Combinational extended-Hamming check: syndrome over positions 1..N and overall parity.
module secded_syndrome
    import secded_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int R      = calc_r(DATA_W),
    localparam int N      = DATA_W + R,
    localparam int CW     = N + 1
) (
    input  logic [CW-1:0] codeword,
    output logic [R-1:0]  syndrome,
    output logic          parity
);

    // NOTE: syndrome is given a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        syndrome = '0;
        for (int k = 0; k < N; k++) begin
            if (codeword[k]) syndrome = syndrome ^ R'(k + 1);
        end
        parity = ^codeword;
    end

endmodule

// File: rtl/secded_dec_pipe.sv
// Two-stage SECDED decoder: stage 1 holds codeword/syndrome, stage 2 the corrected beat.
module secded_dec_pipe
    import secded_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input logic              i_clk,
    input logic              i_rst_n,
    secded_dec_pipe_if.slave bus
);
    localparam int R  = calc_r(DATA_W);
    localparam int N  = DATA_W + R;
    localparam int CW = N + 1;

    logic                  en1, en2, handshake;
    logic [R-1:0]          syn_c;
    logic                  par_c;

    logic                  v1;
    logic [CW-1:0]         cw1;
    logic [R-1:0]          syn1;
    logic                  par1;

    logic                  v2;
    logic [DATA_W-1:0]     data2;
    logic [R-1:0]          syn2;
    logic                  sec2, ded2;

    logic [CNT_W-1:0]      sec_cnt, ded_cnt;

    secded_class_e         cls;
    logic [CW-1:0]         flip;
    logic [MAX_DATA_W-1:0] extracted;
    logic                  unused_extract_hi;

    secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .codeword (bus.i_data),
        .syndrome (syn_c),
        .parity   (par_c)
    );

    assign en2         = !v2 || bus.i_ready;
    assign en1         = !v1 || en2;
    assign handshake   = v2 && bus.i_ready;
    assign bus.o_ready = i_rst_n && en1;

    // NOTE: the stage-1 payload is only observed behind v1, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (en1 && bus.i_valid) begin
            cw1  <= bus.i_data;
            syn1 <= syn_c;
            par1 <= par_c;
        end
    end

    // A syndrome beyond N cannot name a bit, so an odd-parity word with one is uncorrectable.
    always_comb begin
        cls  = CLEAN;
        flip = '0;
        if (syn1 == '0) begin
            cls = par1 ? SEC : CLEAN;
        end else if (!par1 || int'(syn1) > N) begin
            cls = DED;
        end else begin
            cls  = SEC;
            flip = CW'(1) << (syn1 - 1'b1);
        end
        extracted = extract_data(MAX_CW'(cw1 ^ flip), N);
    end

    assign unused_extract_hi = ^extracted[MAX_DATA_W-1:DATA_W];

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            data2 <= '0;
            syn2  <= '0;
            sec2  <= 1'b0;
            ded2  <= 1'b0;
        end else begin
            if (en1) v1 <= bus.i_valid;
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    data2 <= extracted[DATA_W-1:0];
                    syn2  <= syn1;
                    sec2  <= (cls == SEC);
                    ded2  <= (cls == DED);
                end
            end
        end
    end

    // Clear wins over a coincident event; both counters stick at all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (handshake) begin
            if (sec2 && sec_cnt != '1) sec_cnt <= sec_cnt + 1'b1;
            if (ded2 && ded_cnt != '1) ded_cnt <= ded_cnt + 1'b1;
        end
    end

    assign bus.o_valid                     = v2;
    assign bus.o_data                      = data2;
    assign bus.o_syndrome                  = syn2;
    assign bus.o_single_bit_error_detected = sec2;
    assign bus.o_2_bit_error_detected      = ded2;
    assign bus.o_sec_cnt                   = sec_cnt;
    assign bus.o_ded_cnt                   = ded_cnt;

endmodule

// File: tb/tb_secded_dec_pipe.sv
// Directed bench for secded_dec_pipe with DATA_W=8 and 4-bit counters.
module tb_secded_dec_pipe;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [12:0] cw;
        logic [7:0]  data;
        logic [3:0]  syn;
        logic        sec;
        logic        ded;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    secded_dec_pipe_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    secded_dec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_sec = '0;
    logic [CNT_W-1:0] exp_ded = '0;

    // Hand-computed: clean, data-bit error, overall-parity error, double error, invalid syndrome.
    vec_t vecs [5] = '{
        '{13'h0A27, 8'hA5, 4'd0,  1'b0, 1'b0},
        '{13'h0A07, 8'hA5, 4'd6,  1'b1, 1'b0},
        '{13'h1A27, 8'hA5, 4'd0,  1'b1, 1'b0},
        '{13'h0A03, 8'hA0, 4'd5,  1'b0, 1'b1},
        '{13'h0AAE, 8'hA5, 4'd13, 1'b0, 1'b1}
    };

    // Hand-encoded clean words with distinct payloads, plus one corrected word.
    vec_t bp [6] = '{
        '{13'h0A27, 8'hA5, 4'd0, 1'b0, 1'b0},
        '{13'h0F77, 8'hFF, 4'd0, 1'b0, 1'b0},
        '{13'h1007, 8'h01, 4'd0, 1'b0, 1'b0},
        '{13'h1888, 8'h80, 4'd0, 1'b0, 1'b0},
        '{13'h1362, 8'h3C, 4'd0, 1'b0, 1'b0},
        '{13'h0A07, 8'hA5, 4'd6, 1'b1, 1'b0}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    task automatic check_beat(input string tag, input vec_t v);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'(1));
        check({tag, "_data"},  32'(bus.o_data), 32'(v.data));
        check({tag, "_syn"},   32'(bus.o_syndrome), 32'(v.syn));
        check({tag, "_sec"},   32'(bus.o_single_bit_error_detected), 32'(v.sec));
        check({tag, "_ded"},   32'(bus.o_2_bit_error_detected), 32'(v.ded));
    endtask

    task automatic run_one(input string tag, input vec_t v, input logic clr);
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = v.cw;
        #1;
        check({tag, "_in_ready"}, 32'(bus.o_ready), 32'(1));
        tick;
        bus.i_valid = 1'b0;
        check({tag, "_lat1"}, 32'(bus.o_valid), 32'(0));
        tick;
        check_beat(tag, v);
        bus.i_cnt_clr = clr;
        tick;
        bus.i_cnt_clr = 1'b0;
        if (clr) begin
            exp_sec = '0;
            exp_ded = '0;
        end else begin
            if (v.sec) exp_sec = sat_inc(exp_sec);
            if (v.ded) exp_ded = sat_inc(exp_ded);
        end
        check({tag, "_sec_cnt"}, 32'(bus.o_sec_cnt), 32'(exp_sec));
        check({tag, "_ded_cnt"}, 32'(bus.o_ded_cnt), 32'(exp_ded));
        check({tag, "_drained"}, 32'(bus.o_valid), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},   32'(bus.o_ready), 32'(0));
        check({tag, "_valid"},   32'(bus.o_valid), 32'(0));
        check({tag, "_data"},    32'(bus.o_data), 32'(0));
        check({tag, "_syn"},     32'(bus.o_syndrome), 32'(0));
        check({tag, "_sec"},     32'(bus.o_single_bit_error_detected), 32'(0));
        check({tag, "_ded"},     32'(bus.o_2_bit_error_detected), 32'(0));
        check({tag, "_sec_cnt"}, 32'(bus.o_sec_cnt), 32'(0));
        check({tag, "_ded_cnt"}, 32'(bus.o_ded_cnt), 32'(0));
    endtask

    initial begin
        int   sent, rcvd;
        logic held;
        logic [7:0] held_data;
        logic [3:0] held_syn;

        bus.i_valid   = 1'b0;
        bus.i_data    = '0;
        bus.i_ready   = 1'b0;
        bus.i_cnt_clr = 1'b0;
        rst_n         = 1'b0;
        tick;
        tick;
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("ready_after_release", 32'(bus.o_ready), 32'(1));

        run_one("clean",    vecs[0], 1'b0);
        run_one("sec_data", vecs[1], 1'b0);
        run_one("sec_par",  vecs[2], 1'b0);
        run_one("ded",      vecs[3], 1'b0);
        run_one("ded_inv",  vecs[4], 1'b0);

        // Six beats with i_ready low for three cycles mid-burst.
        sent = 0;
        rcvd = 0;
        held = 1'b0;
        held_data = '0;
        held_syn  = '0;
        for (int cyc = 0; cyc < 50 && rcvd < 6; cyc++) begin
            bus.i_ready = !(cyc >= 3 && cyc <= 5);
            bus.i_valid = (sent < 6);
            bus.i_data  = bp[(sent < 6) ? sent : 5].cw;
            #1;
            check("bp_ready", 32'(bus.o_ready), 32'(!((sent - rcvd) == 2 && !bus.i_ready)));
            if (held) begin
                check("bp_hold_data", 32'(bus.o_data), 32'(held_data));
                check("bp_hold_syn",  32'(bus.o_syndrome), 32'(held_syn));
            end
            held      = bus.o_valid && !bus.i_ready;
            held_data = bus.o_data;
            held_syn  = bus.o_syndrome;
            if (bus.o_valid && bus.i_ready) begin
                check("bp_order_data", 32'(bus.o_data), 32'(bp[rcvd].data));
                check("bp_order_sec",  32'(bus.o_single_bit_error_detected), 32'(bp[rcvd].sec));
                if (bp[rcvd].sec) exp_sec = sat_inc(exp_sec);
                rcvd++;
            end
            if (bus.i_valid && bus.o_ready) sent++;
            tick;
        end
        bus.i_valid = 1'b0;
        check("bp_count", 32'(rcvd), 32'(6));
        check("bp_no_dup", 32'(bus.o_valid), 32'(0));
        check("bp_sec_cnt", 32'(bus.o_sec_cnt), 32'(exp_sec));

        // Clear, then 17 back-to-back single errors into a 4-bit counter.
        bus.i_cnt_clr = 1'b1;
        tick;
        bus.i_cnt_clr = 1'b0;
        exp_sec = '0;
        exp_ded = '0;
        check("clr_sec_cnt", 32'(bus.o_sec_cnt), 32'(0));
        check("clr_ded_cnt", 32'(bus.o_ded_cnt), 32'(0));
        sent = 0;
        rcvd = 0;
        bus.i_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && rcvd < 17; cyc++) begin
            bus.i_valid = (sent < 17);
            bus.i_data  = 13'h0A07;
            #1;
            check("sat_ready", 32'(bus.o_ready), 32'(1));
            check("sat_cnt", 32'(bus.o_sec_cnt), 32'(exp_sec));
            if (bus.o_valid) begin
                check("sat_data", 32'(bus.o_data), 32'(8'hA5));
                exp_sec = sat_inc(exp_sec);
                rcvd++;
            end
            if (bus.i_valid && bus.o_ready) sent++;
            tick;
        end
        bus.i_valid = 1'b0;
        check("sat_count", 32'(rcvd), 32'(17));
        check("sat_final", 32'(bus.o_sec_cnt), 32'(4'hF));

        // Clear coincides with a ded handshake: nothing counted.
        run_one("clr_vs_ded", vecs[3], 1'b1);

        // Reset with two beats stalled in the pipe.
        run_one("pre_rst", vecs[1], 1'b0);
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 13'h0A07;
        tick;
        bus.i_data  = 13'h0A03;
        tick;
        bus.i_valid = 1'b0;
        check("rst_inflight_valid", 32'(bus.o_valid), 32'(1));
        check("rst_inflight_ready", 32'(bus.o_ready), 32'(0));
        rst_n = 1'b0;
        tick;
        check_all_zero("mid_reset");
        exp_sec = '0;
        exp_ded = '0;
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        #1;
        check("rst_release_ready", 32'(bus.o_ready), 32'(1));
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick;
            check("rst_flushed", 32'(bus.o_valid), 32'(0));
        end
        check("rst_sec_cnt", 32'(bus.o_sec_cnt), 32'(exp_sec));
        check("rst_ded_cnt", 32'(bus.o_ded_cnt), 32'(exp_ded));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
